// File: rtl/instr_mem.sv
// Instruction memory with a self-initialising fill sequence, a registered read port and a
// write-protected program-load port.
//
// state | meaning
// INIT  | writing DEFAULT_WORD to words 0..DEPTH-1, one per cycle; ports ignored
// RUN   | ready asserted, read and program-load ports active
module instr_mem #(
  parameter int                DATA_W       = 32,
  parameter int                ADDR_W       = 16,
  parameter int                DEPTH        = 16,
  parameter logic [DATA_W-1:0] DEFAULT_WORD = DATA_W'(32'hD600_03E0)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_err,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              lock,
  output logic              wr_err
);

  localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
  // One extra bit so DEPTH == 2^ADDR_W is representable and the compare stays full-width.
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]        state;
  logic [IDX_W-1:0]  init_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic             run;
  logic             rd_in_range;
  logic             wr_in_range;
  logic             wr_ok;
  logic             wr_reject;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;

  assign run         = (state == RUN);
  assign ready       = run;
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);
  assign rd_idx      = rd_addr[IDX_W-1:0];
  assign wr_idx      = wr_addr[IDX_W-1:0];
  assign wr_ok       = run && wr_en && !lock && wr_in_range;
  assign wr_reject   = run && wr_en && (lock || !wr_in_range);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      case (state)
        INIT: begin
          if (init_cnt == LAST_IDX) state <= RUN;
          else                      init_cnt <= init_cnt + 1'b1;
        end
        default: state <= RUN;
      endcase
    end
  end

  // Array carries no reset: the INIT sweep restores every word after any reset.
  always_ff @(posedge clk) begin
    if (!run)       mem[init_cnt] <= DEFAULT_WORD;
    else if (wr_ok) mem[wr_idx]   <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= DEFAULT_WORD;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      rd_valid <= run && rd_en;
      rd_err   <= run && rd_en && !rd_in_range;
      wr_err   <= wr_reject;
      if (run && rd_en) rd_data <= rd_in_range ? mem[rd_idx] : DEFAULT_WORD;
    end
  end

endmodule
